// File: rtl/channel_sample_history_if.sv
// Bundle of write, clear, freeze and read-port signals for channel_sample_history.
// master drives requests; slave is the history buffer.
interface channel_sample_history_if #(
    parameter int NUM_CHANNELS = 14,
    parameter int SAMPLE_WIDTH = 8,
    parameter int DEPTH        = 10
);
    localparam int CH_W  = $clog2(NUM_CHANNELS);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                    ena;
    logic                    wr_en;
    logic [CH_W-1:0]         wr_ch;
    logic [SAMPLE_WIDTH-1:0] wr_data;
    logic                    clr_en;
    logic [CH_W-1:0]         clr_ch;
    logic                    freeze;
    logic                    rd_req;
    logic [CH_W-1:0]         rd_ch;
    logic [IDX_W-1:0]        rd_idx;
    logic                    rd_valid;
    logic [SAMPLE_WIDTH-1:0] rd_data;
    logic                    rd_err;
    logic [CNT_W-1:0]        rd_count;

    modport master (
        output ena, wr_en, wr_ch, wr_data, clr_en, clr_ch, freeze, rd_req, rd_ch, rd_idx,
        input  rd_valid, rd_data, rd_err, rd_count
    );

    modport slave (
        input  ena, wr_en, wr_ch, wr_data, clr_en, clr_ch, freeze, rd_req, rd_ch, rd_idx,
        output rd_valid, rd_data, rd_err, rd_count
    );
endinterface

// File: rtl/channel_sample_history.sv
// Per-channel sample history (newest at index 0) with fill counts and a 1-cycle read port.
// Optional global freeze of writes/clears under macro CHANNEL_HISTORY_FREEZE_EN.
module channel_sample_history #(
    parameter int NUM_CHANNELS = 14,
    parameter int SAMPLE_WIDTH = 8,
    parameter int DEPTH        = 10
) (
    input logic clk,
    input logic rst_n,
    channel_sample_history_if.slave bus
);
    localparam int CH_W  = $clog2(NUM_CHANNELS);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CHX_W = CH_W + 1;

    logic [SAMPLE_WIDTH-1:0] mem   [NUM_CHANNELS][DEPTH];
    logic [CNT_W-1:0]        count [NUM_CHANNELS];

    logic                    blocked;
    logic                    wr_ok, clr_ok, rd_ch_ok, rd_idx_ok;
    logic [NUM_CHANNELS-1:0] wr_hit, clr_hit;
    logic [CNT_W-1:0]        rd_cnt_sel;
    logic [SAMPLE_WIDTH-1:0] rd_data_sel;

`ifdef CHANNEL_HISTORY_FREEZE_EN
    logic frozen_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frozen_q <= 1'b0;
        end else if (bus.ena) begin
            frozen_q <= bus.freeze;
        end
    end

    assign blocked = frozen_q;
`else
    logic unused_freeze;
    assign unused_freeze = bus.freeze;
    assign blocked       = 1'b0;
`endif

    assign wr_ok  = CHX_W'(bus.wr_ch)  < CHX_W'(NUM_CHANNELS);
    assign clr_ok = CHX_W'(bus.clr_ch) < CHX_W'(NUM_CHANNELS);

    always_comb begin
        wr_hit  = '0;
        clr_hit = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            wr_hit[c]  = bus.ena && !blocked && bus.wr_en  && wr_ok  && (bus.wr_ch  == CH_W'(c));
            clr_hit[c] = bus.ena && !blocked && bus.clr_en && clr_ok && (bus.clr_ch == CH_W'(c));
        end
    end

    // A clear in the same cycle as a write restarts the count at the new sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                count[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (wr_hit[c]) begin
                    if (clr_hit[c]) begin
                        count[c] <= CNT_W'(1);
                    end else if (count[c] != CNT_W'(DEPTH)) begin
                        count[c] <= count[c] + CNT_W'(1);
                    end
                end else if (clr_hit[c]) begin
                    count[c] <= '0;
                end
            end
        end
    end

    // Entry contents are gated by count on readout, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (wr_hit[c]) begin
                for (int d = DEPTH - 1; d > 0; d--) begin
                    mem[c][d] <= mem[c][d-1];
                end
                mem[c][0] <= bus.wr_data;
            end
        end
    end

    always_comb begin
        rd_ch_ok    = CHX_W'(bus.rd_ch) < CHX_W'(NUM_CHANNELS);
        rd_cnt_sel  = rd_ch_ok ? count[bus.rd_ch] : '0;
        rd_idx_ok   = CNT_W'(bus.rd_idx) < rd_cnt_sel;
        rd_data_sel = '0;
        if (rd_ch_ok && rd_idx_ok) begin
            rd_data_sel = mem[bus.rd_ch][bus.rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_valid <= 1'b0;
            bus.rd_err   <= 1'b0;
            bus.rd_data  <= '0;
            bus.rd_count <= '0;
        end else begin
            bus.rd_valid <= bus.rd_req;
            if (bus.rd_req) begin
                bus.rd_err   <= !(rd_ch_ok && rd_idx_ok);
                bus.rd_data  <= rd_data_sel;
                bus.rd_count <= rd_cnt_sel;
            end else begin
                bus.rd_err   <= 1'b0;
                bus.rd_data  <= '0;
                bus.rd_count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_channel_sample_history.sv
// Directed bench for channel_sample_history (14 ch x 10 deep x 8 bit).
module tb_channel_sample_history;
    logic clk;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;

    channel_sample_history_if #(.NUM_CHANNELS(14), .SAMPLE_WIDTH(8), .DEPTH(10)) bus ();

    channel_sample_history #(.NUM_CHANNELS(14), .SAMPLE_WIDTH(8), .DEPTH(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] ch, input logic [7:0] data);
        bus.wr_en = 1'b1; bus.wr_ch = ch; bus.wr_data = data;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] ch, input logic [3:0] idx,
                      input logic err, input logic [7:0] data, input logic [3:0] cnt);
        bus.rd_req = 1'b1; bus.rd_ch = ch; bus.rd_idx = idx;
        tick();
        bus.rd_req = 1'b0;
        chk({tag, ".valid"}, 32'(bus.rd_valid), 32'd1);
        chk({tag, ".err"},   32'(bus.rd_err),   32'(err));
        chk({tag, ".data"},  32'(bus.rd_data),  32'(data));
        chk({tag, ".count"}, 32'(bus.rd_count), 32'(cnt));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.ena = 1'b1; bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_data = '0;
        bus.clr_en = 1'b0; bus.clr_ch = '0; bus.freeze = 1'b0;
        bus.rd_req = 1'b0; bus.rd_ch = '0; bus.rd_idx = '0;
        #1;
        chk("reset.valid", 32'(bus.rd_valid), 32'd0);
        chk("reset.err",   32'(bus.rd_err),   32'd0);
        chk("reset.data",  32'(bus.rd_data),  32'd0);
        chk("reset.count", 32'(bus.rd_count), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        rd("empty_ch0", 4'd0, 4'd0, 1'b1, 8'h00, 4'd0);
        tick();
        chk("idle.valid", 32'(bus.rd_valid), 32'd0);

        wr(4'd3, 8'h11); wr(4'd3, 8'h22); wr(4'd3, 8'h33);
        rd("ch3.i0", 4'd3, 4'd0, 1'b0, 8'h33, 4'd3);
        rd("ch3.i1", 4'd3, 4'd1, 1'b0, 8'h22, 4'd3);
        rd("ch3.i2", 4'd3, 4'd2, 1'b0, 8'h11, 4'd3);
        rd("ch3.i3", 4'd3, 4'd3, 1'b1, 8'h00, 4'd3);

        for (int i = 1; i <= 12; i++) wr(4'd13, 8'(i));
        rd("ch13.i0", 4'd13, 4'd0, 1'b0, 8'd12, 4'd10);
        rd("ch13.i9", 4'd13, 4'd9, 1'b0, 8'd3,  4'd10);
        rd("ch12.i0", 4'd12, 4'd0, 1'b1, 8'h00, 4'd0);

        bus.wr_en = 1'b1; bus.wr_ch = 4'd5; bus.wr_data = 8'hAA;
        rd("ch5.rdwr", 4'd5, 4'd0, 1'b1, 8'h00, 4'd0);
        bus.wr_en = 1'b0;
        rd("ch5.after", 4'd5, 4'd0, 1'b0, 8'hAA, 4'd1);
        wr(4'd5, 8'hA1);
        bus.clr_en = 1'b1; bus.clr_ch = 4'd5;
        wr(4'd5, 8'h5B);
        bus.clr_en = 1'b0;
        rd("ch5.clrwr.i0", 4'd5, 4'd0, 1'b0, 8'h5B, 4'd1);
        rd("ch5.clrwr.i1", 4'd5, 4'd1, 1'b1, 8'h00, 4'd1);

        bus.clr_en = 1'b1; bus.clr_ch = 4'd3;
        wr(4'd4, 8'h44);
        bus.clr_en = 1'b0;
        rd("ch3.cleared", 4'd3, 4'd0, 1'b1, 8'h00, 4'd0);
        rd("ch4.written", 4'd4, 4'd0, 1'b0, 8'h44, 4'd1);

        bus.wr_en = 1'b1; bus.wr_ch = 4'd14; bus.wr_data = 8'hEE;
        rd("bad_rd_ch", 4'd15, 4'd0, 1'b1, 8'h00, 4'd0);
        bus.wr_en = 1'b0;
        rd("ch13.untouched", 4'd13, 4'd0, 1'b0, 8'd12, 4'd10);
        rd("ch14.bad", 4'd14, 4'd0, 1'b1, 8'h00, 4'd0);

        bus.ena = 1'b0;
        wr(4'd4, 8'h99);
        bus.clr_en = 1'b1; bus.clr_ch = 4'd4;
        tick();
        bus.clr_en = 1'b0;
        rd("ena_low.ch4", 4'd4, 4'd0, 1'b0, 8'h44, 4'd1);
        bus.ena = 1'b1;

`ifdef CHANNEL_HISTORY_FREEZE_EN
        bus.freeze = 1'b1;
        tick();
        wr(4'd1, 8'h77);
        rd("frozen.ch1", 4'd1, 4'd0, 1'b1, 8'h00, 4'd0);
        bus.freeze = 1'b0;
        tick();
        wr(4'd1, 8'h78);
        rd("thawed.ch1", 4'd1, 4'd0, 1'b0, 8'h78, 4'd1);
`else
        bus.freeze = 1'b1;
        tick();
        wr(4'd1, 8'h77);
        bus.freeze = 1'b0;
        rd("nofreeze.ch1", 4'd1, 4'd0, 1'b0, 8'h77, 4'd1);
`endif

        bus.rd_req = 1'b1; bus.rd_ch = 4'd13; bus.rd_idx = 4'd0;
        tick();
        chk("burst.data", 32'(bus.rd_data), 32'd12);
        tick();
        chk("burst.valid", 32'(bus.rd_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.valid", 32'(bus.rd_valid), 32'd0);
        chk("midrst.data",  32'(bus.rd_data),  32'd0);
        chk("midrst.count", 32'(bus.rd_count), 32'd0);
        tick();
        chk("inrst.valid", 32'(bus.rd_valid), 32'd0);
        bus.rd_req = 1'b0;
        rst_n = 1'b1;
        tick();
        rd("postrst.ch13", 4'd13, 4'd0, 1'b1, 8'h00, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/channel_sample_history.md
# channel_sample_history

- Multi-channel sample history buffer, the parametrised successor of the per-channel shift buffers in the Tiny Tapeout top.
- Each of NUM_CHANNELS channels keeps its last DEPTH samples of SAMPLE_WIDTH bits, with a per-channel fill count.
- Channel writes are addressed; any channel and history index can be read back with fixed one-cycle latency.
- Instantiated under the tt_um top, between the ui_in sampling logic and the uo_out/uio readout mux.

## Interface
Parameters:
- NUM_CHANNELS, 14, number of independent channels (>= 2)
- SAMPLE_WIDTH, 8, bits per sample
- DEPTH, 10, samples retained per channel (>= 2)
- Derived: CH_W = $clog2(NUM_CHANNELS), IDX_W = $clog2(DEPTH), CNT_W = $clog2(DEPTH+1)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, active-low, asynchronous assert, synchronous deassert handled upstream
- ena  in  1  design enable; low blocks writes, clears and freeze changes
- wr_en  in  1  push wr_data into channel wr_ch this cycle
- wr_ch  in  CH_W  write channel
- wr_data  in  SAMPLE_WIDTH  sample value
- clr_en  in  1  empty channel clr_ch
- clr_ch  in  CH_W  clear channel
- freeze  in  1  freeze all histories (only with CHANNEL_HISTORY_FREEZE_EN)
- rd_req  in  1  read request
- rd_ch  in  CH_W  read channel
- rd_idx  in  IDX_W  age of sample, 0 = newest
- rd_valid  out  1  read response strobe
- rd_data  out  SAMPLE_WIDTH  read sample
- rd_err  out  1  response invalid (bad channel, or index >= count)
- rd_count  out  CNT_W  fill count of rd_ch at request time

## Operation
- Storage: per channel, DEPTH entries plus a count register.
- Write (ena & wr_en & wr_ch < NUM_CHANNELS):
  - entries shift by one age; wr_data becomes index 0; the oldest entry is dropped when full.
  - count increments, saturating at DEPTH.
- wr_ch >= NUM_CHANNELS: write ignored, no state change.
- Clear (ena & clr_en & valid clr_ch): count <= 0. Entry contents are don't-care, but must never be returned as valid data.
- Clear and write to the same channel in the same cycle: clear first, then write. Result: count = 1, index 0 = wr_data.
- Clear and write to different channels: both take effect.
- Read (rd_req, independent of ena):
  - Registered response next cycle: rd_valid = 1, rd_count = count of rd_ch.
  - If rd_ch >= NUM_CHANNELS: rd_err = 1, rd_data = 0, rd_count = 0.
  - Else if rd_idx >= count: rd_err = 1, rd_data = 0.
  - Else: rd_err = 0, rd_data = entry[rd_idx].
- Read and write to the same channel in the same cycle: the read returns the pre-write contents and pre-write count.
- No state machine beyond the per-channel count. The read port is a single-stage pipeline and accepts a request every cycle.

## Timing
- Reset (rst_n low, asynchronous):
  - all counts = 0; rd_valid, rd_err = 0; rd_data, rd_count = 0; freeze latch = 0.
  - Entry contents need not be reset.
- Write/clear effects are visible to a read requested the following cycle.
- Read latency: exactly 1 cycle, from the rd_req edge to the rd_valid pulse.
- Back-to-back rd_req gives rd_valid high continuously.
- rd_valid is low in any cycle following no request.
- Reset mid-read: a pending response is dropped, and rd_valid stays 0 through reset.

## Configuration
- Macro CHANNEL_HISTORY_FREEZE_EN.
- Defined:
  - freeze is sampled when ena = 1.
  - While frozen, all writes and clears are ignored and counts hold.
  - Reads are unaffected.
  - Unfreezing resumes normal operation on the next cycle.
- Undefined:
  - freeze port is present but ignored, and no freeze register is synthesised.

## Test plan
- Reset, then read ch0 idx0 -> rd_valid = 1, rd_err = 1, rd_count = 0, rd_data = 0.
- Write 0x11, 0x22, 0x33 to ch3, then read idx0/1/2/3 -> 0x33, 0x22, 0x11 with rd_count = 3, then rd_err = 1.
- Write 12 samples 1..12 to ch13 (DEPTH = 10) -> count 10, idx0 = 12, idx9 = 3; ch12 count = 0.
- Same cycle: write 0xAA to ch5 and read ch5 idx0 (empty) -> response rd_err = 1; read next cycle -> 0xAA, count 1. Clear and write ch5 together -> count 1, idx0 = new data.
- wr_ch = 14, rd_ch = 15 -> no state change, rd_err = 1. ena = 0 with wr_en -> no write. Assert rst_n low mid-burst -> outputs 0 immediately.
- With CHANNEL_HISTORY_FREEZE_EN: freeze = 1, write ch1 -> count unchanged. Release freeze, write -> accepted.
